// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared definitions for the FIFO write-port arbiter:
// FSM state encodings, sizing helper and default word width.
package fifo_wr_arbiter_pkg;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_BURST = 1'b1;

    localparam int DEF_WORDSIZE = 8;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request after
// position 'last', wrapping modulo N.
module fifo_wr_arbiter_rr_pick
    import fifo_wr_arbiter_pkg::*;
#(
    parameter int N = 4,
    localparam int IW = clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic          any,
    output logic [IW-1:0] idx
);

    int   c;
    logic found;

    // Scan last+1 .. last+N so 'last' itself has lowest priority.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        c     = 0;
        for (int k = 1; k <= N; k++) begin
            c = (int'(last) + k) % N;
            if (!found && req[c]) begin
                found = 1'b1;
                idx   = c[IW-1:0];
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing the FIFO write port among
// NREQ producers; honours wfull so no beat is lost or repeated.
module fifo_wr_arbiter
    import fifo_wr_arbiter_pkg::*;
#(
    parameter int NREQ     = 4,
    parameter int WORDSIZE = DEF_WORDSIZE,
    parameter int MAXBURST = 4,
    localparam int IW = clog2(NREQ)
) (
    input  logic                     wclk,
    input  logic                     wrst,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ-1:0]          req_last,
    input  logic [NREQ*WORDSIZE-1:0] req_data,
    output logic [NREQ-1:0]          req_ready,
    input  logic                     wfull,
    output logic                     winc,
    output logic [WORDSIZE-1:0]      wdata,
    output logic [IW-1:0]            grant_id,
    output logic                     busy
);

    localparam int BW = clog2(MAXBURST + 1);

    logic [0:0]          state;
    logic [IW-1:0]       owner;
    logic [IW-1:0]       last_owner;
    logic [BW-1:0]       beat_cnt;
    logic                pick_any;
    logic [IW-1:0]       pick_idx;
    logic                xfer;
    logic                done;
    logic [WORDSIZE-1:0] slot [NREQ];

    for (genvar i = 0; i < NREQ; i++) begin : g_slot
        assign slot[i] = req_data[i*WORDSIZE +: WORDSIZE];
    end

    fifo_wr_arbiter_rr_pick #(
        .N    (NREQ)
    ) u_pick (
        .req  (req_valid),
        .last (last_owner),
        .any  (pick_any),
        .idx  (pick_idx)
    );

    assign xfer  = (state == ST_BURST) & req_valid[owner] & ~wfull;
    assign done  = req_last[owner] | (beat_cnt == BW'(MAXBURST - 1));
    assign winc  = xfer;
    assign wdata = xfer ? slot[owner] : '0;

    assign grant_id = owner;
    assign busy     = (state == ST_BURST);

    always_comb begin
        req_ready = '0;
        if (state == ST_BURST)
            req_ready[owner] = ~wfull;
    end

    // An owner that drops valid keeps the grant until its last beat.
    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            state      <= ST_IDLE;
            owner      <= '0;
            last_owner <= IW'(NREQ - 1);
            beat_cnt   <= '0;
        end else begin
            unique case (1'b1)
                (state == ST_IDLE): begin
                    if (pick_any) begin
                        state    <= ST_BURST;
                        owner    <= pick_idx;
                        beat_cnt <= '0;
                    end
                end
                (state == ST_BURST): begin
                    if (xfer) begin
                        if (done) begin
                            state      <= ST_IDLE;
                            last_owner <= owner;
                            beat_cnt   <= '0;
                        end else begin
                            beat_cnt <= beat_cnt + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed scenarios plus random traffic,
// all outputs compared against a burst-level reference model.
module tb_fifo_wr_arbiter;

    localparam int NREQ = 4;
    localparam int W    = 8;
    localparam int MB   = 4;
    localparam int IW   = 2;

    logic            wclk = 1'b0;
    logic            wrst = 1'b0;
    logic [NREQ-1:0] req_valid = '0;
    logic [NREQ-1:0] req_last  = '0;
    logic [NREQ*W-1:0] req_data = '0;
    logic [NREQ-1:0] req_ready;
    logic            wfull = 1'b0;
    logic            winc;
    logic [W-1:0]    wdata;
    logic [IW-1:0]   grant_id;
    logic            busy;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: m_own = -1 when no burst is in progress.
    int m_own, m_last, m_gid, m_beats;
    logic [W-1:0] pdata [NREQ];
    int wid_q[$];
    int wdat_q[$];
    int grant_q[$];

    fifo_wr_arbiter #(
        .NREQ     (NREQ),
        .WORDSIZE (W),
        .MAXBURST (MB)
    ) dut (
        .wclk      (wclk),
        .wrst      (wrst),
        .req_valid (req_valid),
        .req_last  (req_last),
        .req_data  (req_data),
        .req_ready (req_ready),
        .wfull     (wfull),
        .winc      (winc),
        .wdata     (wdata),
        .grant_id  (grant_id),
        .busy      (busy)
    );

    always #5 wclk = ~wclk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_own   = -1;
        m_last  = NREQ - 1;
        m_gid   = 0;
        m_beats = 0;
    endtask

    task automatic clear_logs();
        wid_q.delete();
        wdat_q.delete();
        grant_q.delete();
    endtask

    // One clock: drive at negedge, check outputs, advance model at posedge.
    task automatic step(input logic [NREQ-1:0] v, input logic [NREQ-1:0] l,
                        input logic f, input logic r);
        logic            x;
        logic [NREQ-1:0] er;
        logic [W-1:0]    ed;
        @(negedge wclk);
        req_valid = v;
        req_last  = l;
        wfull     = f;
        wrst      = r;
        for (int i = 0; i < NREQ; i++) req_data[i*W +: W] = pdata[i];
        if (r) model_reset();
        #1;
        x  = (m_own >= 0) && v[m_own] && !f;
        er = '0;
        if (m_own >= 0 && !f) er[m_own] = 1'b1;
        ed = x ? pdata[m_own] : '0;
        check("winc", winc, x);
        check("wdata", wdata, ed);
        check("req_ready", req_ready, er);
        check("busy", busy, m_own >= 0);
        check("grant_id", grant_id, m_gid);
        if (winc) begin
            wid_q.push_back(int'(grant_id));
            wdat_q.push_back(int'(wdata));
        end
        @(posedge wclk);
        if (!r) begin
            if (m_own < 0) begin
                if (v != '0) begin
                    for (int k = 1; k <= NREQ; k++) begin
                        int c;
                        c = (m_last + k) % NREQ;
                        if (m_own < 0 && v[c]) m_own = c;
                    end
                    m_gid   = m_own;
                    m_beats = 0;
                    grant_q.push_back(m_own);
                end
            end else if (x) begin
                pdata[m_own] = pdata[m_own] + 1'b1;
                m_beats++;
                if (l[m_own] || m_beats == MB) begin
                    m_last  = m_own;
                    m_own   = -1;
                    m_beats = 0;
                end
            end
        end
    endtask

    function automatic int qat(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp2 [4];
        int n2;
        exp2 = '{0, 1, 3, 0};
        for (int i = 0; i < NREQ; i++) pdata[i] = W'(i * 16);
        model_reset();
        #2 wrst = 1'b1;

        // Reset with everyone requesting, then first grant to req 0
        step('1, '1, 1'b0, 1'b1);
        step('1, '1, 1'b0, 1'b1);
        step('1, '1, 1'b0, 1'b0);
        #1;
        check("t1_busy", busy, 1);
        check("t1_gid", grant_id, 0);

        // Round robin over 0,1,3 with single-beat bursts
        step('0, '0, 1'b0, 1'b1);
        clear_logs();
        for (int n = 0; n < 8; n++) step(4'b1011, 4'b1011, 1'b0, 1'b0);
        check("t2_ngrant", grant_q.size(), 4);
        for (int i = 0; i < 4; i++)
            check($sformatf("t2_grant%0d", i), qat(grant_q, i), exp2[i]);
        check("t2_nwrite", wid_q.size(), 4);

        // MAXBURST forces re-arbitration in a long stream
        step('0, '0, 1'b0, 1'b1);
        clear_logs();
        pdata[2] = 8'hA0;
        pdata[1] = 8'h10;
        step(4'b0100, '0, 1'b0, 1'b0);
        for (int n = 0; n < 60 && pdata[2] != 8'hAA; n++)
            step({1'b0, pdata[2] != 8'hAA, 1'b1, 1'b0}, 4'b0010, 1'b0, 1'b0);
        check("t3_done", pdata[2], 8'hAA);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t3_id%0d", i), qat(wid_q, i), 2);
            check($sformatf("t3_d%0d", i), qat(wdat_q, i), 32'hA0 + i);
        end
        check("t3_id4", qat(wid_q, 4), 1);
        check("t3_d4", qat(wdat_q, 4), 32'h10);
        check("t3_id5", qat(wid_q, 5), 2);
        check("t3_d5", qat(wdat_q, 5), 32'hA4);
        n2 = 0;
        foreach (wid_q[i]) if (wid_q[i] == 2) n2++;
        check("t3_n2", n2, 10);

        // Backpressure mid-burst
        step('0, '0, 1'b0, 1'b1);
        clear_logs();
        pdata[0] = 8'h40;
        step(4'b0001, '0, 1'b0, 1'b0);
        step(4'b0001, '0, 1'b0, 1'b0);
        for (int n = 0; n < 3; n++) step(4'b0001, '0, 1'b1, 1'b0);
        for (int n = 0; n < 4; n++) step(4'b0001, '0, 1'b0, 1'b0);
        check("t4_nwrite", wdat_q.size(), 4);
        for (int i = 0; i < 4; i++)
            check($sformatf("t4_d%0d", i), qat(wdat_q, i), 32'h40 + i);
        check("t4_ngrant", grant_q.size(), 2);

        // Owner gap holds the grant
        step('0, '0, 1'b0, 1'b1);
        clear_logs();
        step(4'b0010, '0, 1'b0, 1'b0);
        step(4'b0010, '0, 1'b0, 1'b0);
        for (int n = 0; n < 5; n++) step(4'b0001, '0, 1'b0, 1'b0);
        #1;
        check("t5_gid_hold", grant_id, 1);
        check("t5_busy_hold", busy, 1);
        check("t5_nwrite", wid_q.size(), 1);
        step(4'b0011, 4'b0010, 1'b0, 1'b0);
        step(4'b0011, '0, 1'b0, 1'b0);
        #1;
        check("t5_gid_next", grant_id, 0);

        // Reset mid-burst after two beats
        step('0, '0, 1'b0, 1'b1);
        clear_logs();
        pdata[3] = 8'h30;
        step(4'b1000, '0, 1'b0, 1'b0);
        step(4'b1000, '0, 1'b0, 1'b0);
        step(4'b1000, '0, 1'b0, 1'b0);
        step(4'b1001, '0, 1'b0, 1'b1);
        step(4'b1001, '0, 1'b0, 1'b0);
        #1;
        check("t6_gid", grant_id, 0);
        check("t6_nwrite", wdat_q.size(), 2);
        check("t6_d0", qat(wdat_q, 0), 32'h30);
        check("t6_d1", qat(wdat_q, 1), 32'h31);

        // Random traffic with occasional reset
        step('0, '0, 1'b0, 1'b1);
        for (int n = 0; n < 400; n++)
            step(4'($urandom), 4'($urandom), $urandom_range(0, 3) == 0,
                 $urandom_range(0, 99) == 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
